// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port SRAM arbiter between IF fetch and MEM load/store with pipeline freeze
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              freeze_if,
   output logic              freeze_pipe,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, MEM_BUSY = 2'd2} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              sram_we_q, sram_we_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              mem_ready_q, mem_ready_d;
   logic              mem_elig;
   logic              if_elig;

   // The ready term keeps a request the pipeline has not yet advanced past from being re-granted.
   assign mem_elig = (mem_r_en | mem_w_en) & ~mem_ready_q;
   assign if_elig  = if_req & ~if_ready_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sram_we_d    = sram_we_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      if_ready_d   = 1'b0;
      mem_ready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_elig) begin
               sram_addr_d  = mem_addr;
               sram_wdata_d = mem_wdata;
               sram_we_d    = mem_w_en;
               cnt_d        = CNT_INIT;
               state_d      = MEM_BUSY;
            end else if (if_elig) begin
               sram_addr_d  = if_addr;
               sram_wdata_d = mem_wdata;
               sram_we_d    = 1'b0;
               cnt_d        = CNT_INIT;
               state_d      = IF_BUSY;
            end
         end
         IF_BUSY, MEM_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
               if (state_q == IF_BUSY) begin
                  if_rdata_d = sram_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  if (!sram_we_q) begin
                     mem_rdata_d = sram_rdata;
                  end
                  mem_ready_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_ready_q   <= 1'b0;
         mem_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         if_ready_q   <= if_ready_d;
         mem_ready_q  <= mem_ready_d;
      end
   end

   assign sram_en     = (state_q != IDLE);
   assign busy        = (state_q != IDLE);
   assign sram_we     = sram_we_q;
   assign sram_addr   = sram_addr_q;
   assign sram_wdata  = sram_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign mem_rdata   = mem_rdata_q;
   assign if_ready    = if_ready_q;
   assign mem_ready   = mem_ready_q;
   assign freeze_pipe = mem_elig;
   assign freeze_if   = mem_elig | if_elig;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int W = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_r_en, mem_w_en;
   logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
   logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
   logic        if_ready, mem_ready, sram_en, sram_we, freeze_if, freeze_pipe, busy;

   logic        if_req1, mem_r_en1, mem_w_en1;
   logic [31:0] if_addr1, mem_addr1, mem_wdata1, sram_rdata1;
   logic [31:0] if_rdata1, mem_rdata1, sram_addr1, sram_wdata1;
   logic        if_ready1, mem_ready1, sram_en1, sram_we1, freeze_if1, freeze_pipe1, busy1;

   int checks = 0;
   int errors = 0;
   int en_run;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sram_en(sram_en),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .freeze_if(freeze_if), .freeze_pipe(freeze_pipe), .busy(busy));

   mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) dut1 (
      .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
      .if_ready(if_ready1), .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .sram_en(sram_en1),
      .sram_we(sram_we1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
      .freeze_if(freeze_if1), .freeze_pipe(freeze_pipe1), .busy(busy1));

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h10)  return 32'hE3A00001;
      if (a == 32'h300) return 32'h5;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
   endfunction

   // Memory only drives real data in the last enabled cycle of an access.
   always @(posedge clk or negedge rst) begin
      if (!rst) en_run <= 0;
      else      en_run <= sram_en ? en_run + 1 : 0;
   end
   assign sram_rdata  = (sram_en && en_run == W - 1) ? mem_f(sram_addr) : 32'hBAD0BAD0;
   assign sram_rdata1 = sram_en1 ? mem_f(sram_addr1) : 32'hBAD0BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic ir; logic [31:0] ia; logic mr, mw; logic [31:0] ma, md;
      logic en, we; logic [31:0] sa, sd;
      logic ird, mrd, fi, fp; logic [31:0] ird_d, mrd_d;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                      input logic [31:0] ma, input logic [31:0] md, input logic en, input logic we,
                      input logic [31:0] sa, input logic [31:0] sd, input logic ird, input logic mrd,
                      input logic fi, input logic fp, input logic [31:0] ird_d, input logic [31:0] mrd_d);
      vec_t v;
      v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.md = md; v.en = en; v.we = we;
      v.sa = sa; v.sd = sd; v.ird = ird; v.mrd = mrd; v.fi = fi; v.fp = fp;
      v.ird_d = ird_d; v.mrd_d = mrd_d;
      tbl.push_back(v);
   endtask

   task automatic clear_inputs();
      if_req = 0; mem_r_en = 0; mem_w_en = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;
   endtask

   int          rdy_c[$], gnt_c[$];
   logic [31:0] gaddr[$];
   logic        prev_en, rdy_seen;
   logic [31:0] pc;
   int          k;

   int          g_t, d_t;
   logic        own_mem, m_we, busy_e, ird_e, mrd_e, fp_e, fi_e;
   logic [31:0] m_a, m_d, e_ird, e_mrd;

   localparam logic [31:0] E = 32'hE3A00001;

   initial begin
      rst = 0;
      clear_inputs();
      if_req1 = 0; mem_r_en1 = 0; mem_w_en1 = 0; if_addr1 = 0; mem_addr1 = 0; mem_wdata1 = 0;
      step(); step();
      @(negedge clk);
      chk("rst_en", sram_en, 0);       chk("rst_we", sram_we, 0);
      chk("rst_busy", busy, 0);        chk("rst_if_ready", if_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_addr", sram_addr, 0);   chk("rst_wdata", sram_wdata, 0);
      step();
      rst = 1;

      // Single-cycle latency instance
      mem_r_en1 = 1; mem_addr1 = 32'h40;
      @(negedge clk); chk("w1_c0_en", sram_en1, 0);
      step();
      @(negedge clk); chk("w1_c1_en", sram_en1, 1); chk("w1_c1_ready", mem_ready1, 0);
      step();
      @(negedge clk); chk("w1_c2_en", sram_en1, 0); chk("w1_c2_ready", mem_ready1, 1);
      chk("w1_c2_rdata", mem_rdata1, mem_f(32'h40));
      step();
      mem_r_en1 = 0;
      @(negedge clk); chk("w1_c3_en", sram_en1, 0); chk("w1_c3_ready", mem_ready1, 0);
      step();

      // IF fetch alone
      add(1,32'h10,0,0,0,0, 0,0,0,0, 0,0,1,0, 0,0);
      for (int i = 0; i < 3; i++) add(1,32'h10,0,0,0,0, 1,0,32'h10,0, 0,0,1,0, 0,0);
      add(1,32'h10,0,0,0,0, 0,0,0,0, 1,0,0,0, E,0);
      add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, E,0);
      // Simultaneous IF and MEM
      add(1,32'h20,1,0,32'h100,0, 0,0,0,0, 0,0,1,1, E,0);
      for (int i = 0; i < 3; i++) add(1,32'h20,1,0,32'h100,0, 1,0,32'h100,0, 0,0,1,1, E,0);
      add(1,32'h20,1,0,32'h100,0, 0,0,0,0, 0,1,1,0, E,mem_f(32'h100));
      for (int i = 0; i < 3; i++) add(1,32'h20,0,0,0,0, 1,0,32'h20,0, 0,0,1,0, E,mem_f(32'h100));
      add(1,32'h20,0,0,0,0, 0,0,0,0, 1,0,0,0, mem_f(32'h20),mem_f(32'h100));
      add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, mem_f(32'h20),mem_f(32'h100));
      // Load 0x5, then a store (r and w both high) that must leave mem_rdata alone
      add(0,0,1,0,32'h300,0, 0,0,0,0, 0,0,1,1, mem_f(32'h20),mem_f(32'h100));
      for (int i = 0; i < 3; i++) add(0,0,1,0,32'h300,0, 1,0,32'h300,0, 0,0,1,1, mem_f(32'h20),mem_f(32'h100));
      add(0,0,1,0,32'h300,0, 0,0,0,0, 0,1,0,0, mem_f(32'h20),5);
      add(0,0,1,1,32'h200,32'hDEADBEEF, 0,0,0,0, 0,0,1,1, mem_f(32'h20),5);
      for (int i = 0; i < 3; i++) add(0,0,1,1,32'h200,32'hDEADBEEF, 1,1,32'h200,32'hDEADBEEF, 0,0,1,1, mem_f(32'h20),5);
      add(0,0,1,1,32'h200,32'hDEADBEEF, 0,0,0,0, 0,1,0,0, mem_f(32'h20),5);
      add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, mem_f(32'h20),5);

      foreach (tbl[i]) begin
         if_req = tbl[i].ir; if_addr = tbl[i].ia; mem_r_en = tbl[i].mr; mem_w_en = tbl[i].mw;
         mem_addr = tbl[i].ma; mem_wdata = tbl[i].md;
         @(negedge clk);
         chk($sformatf("v%0d_en", i), sram_en, tbl[i].en);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].en);
         if (tbl[i].en) begin
            chk($sformatf("v%0d_addr", i), sram_addr, tbl[i].sa);
            chk($sformatf("v%0d_we", i), sram_we, tbl[i].we);
            if (tbl[i].we) chk($sformatf("v%0d_wdata", i), sram_wdata, tbl[i].sd);
         end
         chk($sformatf("v%0d_if_ready", i), if_ready, tbl[i].ird);
         chk($sformatf("v%0d_mem_ready", i), mem_ready, tbl[i].mrd);
         chk($sformatf("v%0d_freeze_if", i), freeze_if, tbl[i].fi);
         chk($sformatf("v%0d_freeze_pipe", i), freeze_pipe, tbl[i].fp);
         chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].ird_d);
         chk($sformatf("v%0d_mem_rdata", i), mem_rdata, tbl[i].mrd_d);
         step();
      end

      // Continuous fetch: PC advances on each ready pulse
      pc = 32'h1000; prev_en = 0; rdy_seen = 0;
      for (int c = 0; c < 16; c++) begin
         if (rdy_seen) pc = pc + 4;
         if_req = 1; if_addr = pc;
         @(negedge clk);
         rdy_seen = if_ready;
         if (if_ready) rdy_c.push_back(c);
         if (sram_en && !prev_en) begin
            gnt_c.push_back(c - 1);
            gaddr.push_back(sram_addr);
         end
         prev_en = sram_en;
         step();
      end
      if_req = 0;
      chk("fetch_grant_count", gnt_c.size(), 3);
      chk("fetch_ready_count", rdy_c.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < gnt_c.size()) begin
            chk($sformatf("fetch_grant%0d", i), gnt_c[i], 5 * i);
            chk($sformatf("fetch_addr%0d", i), gaddr[i], 32'h1000 + 4 * i);
         end
         if (i < rdy_c.size()) chk($sformatf("fetch_ready%0d", i), rdy_c[i], 5 * i + 4);
      end
      for (int i = 0; i < 6; i++) step();

      // Reset in the middle of a load
      mem_r_en = 1; mem_addr = 32'h300;
      step(); step();
      @(negedge clk);
      chk("mid_en_before", sram_en, 1);
      #1 rst = 0;
      #1;
      chk("mid_rst_en", sram_en, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mem_ready", mem_ready, 0);
      step();
      rst = 1;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (mem_ready) break;
         step();
         k++;
      end
      chk("mid_restart_latency", k, W + 1);
      chk("mid_restart_rdata", mem_rdata, 32'h5);
      step();
      clear_inputs();
      step();

      // Randomized run against a transaction-level model
      rst = 0;
      step(); step();
      rst = 1;
      g_t = -100; d_t = -100; own_mem = 0; m_we = 0; m_a = 0; m_d = 0; e_ird = 0; e_mrd = 0;
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(3) == 0) if_req = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) begin
            mem_r_en = 1'($urandom_range(1));
            mem_w_en = ($urandom_range(2) == 0);
         end
         if_addr   = ($urandom_range(3) == 0) ? 32'h300 : ($urandom() & 32'hFFFC);
         mem_addr  = ($urandom_range(3) == 0) ? 32'h10  : ($urandom() & 32'hFFFC);
         mem_wdata = $urandom();
         @(negedge clk);
         busy_e = (t > g_t) && (t < d_t);
         ird_e  = (t == d_t) && !own_mem;
         mrd_e  = (t == d_t) && own_mem;
         if (ird_e) e_ird = mem_f(m_a);
         if (mrd_e && !m_we) e_mrd = mem_f(m_a);
         fp_e = (mem_r_en | mem_w_en) & !mrd_e;
         fi_e = fp_e | (if_req & !ird_e);
         chk("rnd_en", sram_en, busy_e);
         chk("rnd_busy", busy, busy_e);
         if (busy_e) begin
            chk("rnd_addr", sram_addr, m_a);
            chk("rnd_we", sram_we, m_we);
            if (m_we) chk("rnd_wdata", sram_wdata, m_d);
         end
         chk("rnd_if_ready", if_ready, ird_e);
         chk("rnd_mem_ready", mem_ready, mrd_e);
         chk("rnd_freeze_if", freeze_if, fi_e);
         chk("rnd_freeze_pipe", freeze_pipe, fp_e);
         chk("rnd_if_rdata", if_rdata, e_ird);
         chk("rnd_mem_rdata", mem_rdata, e_mrd);
         if (t >= d_t) begin
            if ((mem_r_en | mem_w_en) && !mrd_e) begin
               own_mem = 1; m_a = mem_addr; m_d = mem_wdata; m_we = mem_w_en;
               g_t = t; d_t = t + W + 1;
            end else if (if_req && !ird_e) begin
               own_mem = 0; m_a = if_addr; m_we = 0;
               g_t = t; d_t = t + W + 1;
            end
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
